spi_slave_port: RTL and testbench

// SPI slave (mode 0: CPOL=0, CPHA=0, MSB first) with a memory-mapped CPU register port.

---
 rtl/spi_slave_port_if.sv | 13 +
 rtl/spi_slave_port.sv | 127 ++++++++++++
 tb/tb_spi_slave_port.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_port_if.sv
// spi_slave_port_if: CPU register-port bus of the SPI slave.
`timescale 1ns/1ps
interface spi_slave_port_if;
  logic        spi_select;
  logic [2:0]  mem_addr;
  logic        read_n;
  logic        write_n;
  logic [15:0] data_from_cpu;
  logic [15:0] data_to_cpu;
  logic        irq;
  modport master (output spi_select, mem_addr, read_n, write_n, data_from_cpu, input data_to_cpu, irq);
  modport slave (input spi_select, mem_addr, read_n, write_n, data_from_cpu, output data_to_cpu, irq);
endinterface

// File: rtl/spi_slave_port.sv
// spi_slave_port: mode-0 SPI slave with a CPU register port; SPI pins are oversampled in the clk domain.
`timescale 1ns/1ps
module spi_slave_port #(
  parameter int DATABITS = 8,
  parameter logic [DATABITS-1:0] IDLE_BYTE = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  spi_slave_port_if.slave bus,
  input  logic            SCLK,
  input  logic            SS_n,
  input  logic            MOSI,
  output logic            MISO,
  output logic            MISO_oe
);
  typedef enum logic {IDLE, ACTIVE} state_t;
  localparam int CW = $clog2(DATABITS + 1);
  state_t state_q, state_d;
  logic [2:0] sclk_q, sclk_d, ss_q, ss_d, mosi_q, mosi_d;
  logic [DATABITS-1:0] rx_shift_q, rx_shift_d, rx_hold_q, rx_hold_d;
  logic [DATABITS-1:0] tx_shift_q, tx_shift_d, tx_hold_q, tx_hold_d;
  logic [CW-1:0] bitcnt_q, bitcnt_d;
  logic primed_q, primed_d, pend_q, pend_d, pend_hold_q, pend_hold_d;
  logic rrdy_q, rrdy_d, roe_q, roe_d, toe_q, toe_d, tur_q, tur_d, abt_q, abt_d;
  logic [5:0] ctrl_q, ctrl_d;
  logic [15:0] data_to_cpu_q, data_to_cpu_d;
  logic irq_q, irq_d;
  logic act, sclk_rise, sclk_fall, ss_fall, ss_rise, done, next_word, commit;
  logic consume, underrun, wr, rd, rd_rx, wr_tx, take, clr;
  logic [6:0] status;
  logic unused_bits;
  assign act = state_q == ACTIVE;
  assign sclk_rise = act & sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = act & ~sclk_q[1] & sclk_q[2];
  assign ss_fall = ~act & ~ss_q[1] & ss_q[2];
  assign ss_rise = act & ss_q[1] & ~ss_q[2];
  assign done = sclk_rise & (bitcnt_q == CW'(DATABITS - 1));
  assign next_word = sclk_fall & (bitcnt_q == '0);
  // A word-boundary reload only takes effect once the next word really starts, so the
  // final SCLK fall of a frame neither eats a primed byte nor flags an underrun.
  assign commit = sclk_rise & pend_q;
  assign consume = (ss_fall & primed_q) | (commit & pend_hold_q);
  assign underrun = (ss_fall & ~primed_q) | (commit & ~pend_hold_q);
  assign wr = bus.spi_select & ~bus.write_n;
  assign rd = bus.spi_select & ~bus.read_n;
  assign rd_rx = rd & (bus.mem_addr == 3'd0);
  assign wr_tx = wr & (bus.mem_addr == 3'd1);
  assign clr = wr & (bus.mem_addr == 3'd2);
  assign take = wr_tx & (~primed_q | consume);
  assign status = {roe_q | toe_q | tur_q | abt_q, rrdy_q, ~primed_q, roe_q, toe_q, tur_q, abt_q};
  assign MISO = act & tx_shift_q[DATABITS-1];
  assign MISO_oe = act;
  assign bus.data_to_cpu = data_to_cpu_q;
  assign bus.irq = irq_q;
  assign unused_bits = ^{bus.data_from_cpu, rx_shift_q[DATABITS-1]};
  always_comb begin
    sclk_d = {sclk_q[1:0], SCLK};
    ss_d = {ss_q[1:0], SS_n};
    mosi_d = {mosi_q[1:0], MOSI};
    state_d = ss_fall ? ACTIVE : ss_rise ? IDLE : state_q;
    bitcnt_d = (ss_fall | ss_rise | done) ? '0 : sclk_rise ? bitcnt_q + 1'b1 : bitcnt_q;
    rx_shift_d = sclk_rise ? {rx_shift_q[DATABITS-2:0], mosi_q[2]} : rx_shift_q;
    rx_hold_d = done ? rx_shift_d : rx_hold_q;
    tx_shift_d = (ss_fall | next_word) ? (primed_q ? tx_hold_q : IDLE_BYTE)
               : sclk_fall ? tx_shift_q << 1 : tx_shift_q;
    pend_d = next_word | (pend_q & ~sclk_rise & ~ss_rise);
    pend_hold_d = next_word ? primed_q : pend_hold_q;
    primed_d = take | (primed_q & ~consume);
    tx_hold_d = take ? bus.data_from_cpu[DATABITS-1:0] : tx_hold_q;
    rrdy_d = done | (rrdy_q & ~rd_rx);
    roe_d = (done & rrdy_q & ~rd_rx) | (roe_q & ~clr);
    toe_d = (wr_tx & ~take) | (toe_q & ~clr);
    tur_d = underrun | (tur_q & ~clr);
    abt_d = (ss_rise & (bitcnt_q != '0)) | (abt_q & ~clr);
    ctrl_d = (wr & (bus.mem_addr == 3'd3)) ? bus.data_from_cpu[8:3] : ctrl_q;
    data_to_cpu_d = ~rd ? data_to_cpu_q
                  : (bus.mem_addr == 3'd0) ? 16'(rx_hold_q)
                  : (bus.mem_addr == 3'd2) ? {6'd0, status, 3'd0}
                  : (bus.mem_addr == 3'd3) ? {7'd0, ctrl_q, 3'd0} : 16'd0;
    irq_d = |(status[5:0] & ctrl_q);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sclk_q <= '0;
      ss_q <= '1;
      mosi_q <= '0;
      bitcnt_q <= '0;
      rx_shift_q <= '0;
      rx_hold_q <= '0;
      tx_shift_q <= '0;
      tx_hold_q <= '0;
      pend_q <= 1'b0;
      pend_hold_q <= 1'b0;
      primed_q <= 1'b0;
      rrdy_q <= 1'b0;
      roe_q <= 1'b0;
      toe_q <= 1'b0;
      tur_q <= 1'b0;
      abt_q <= 1'b0;
      ctrl_q <= '0;
      data_to_cpu_q <= '0;
      irq_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sclk_q <= sclk_d;
      ss_q <= ss_d;
      mosi_q <= mosi_d;
      bitcnt_q <= bitcnt_d;
      rx_shift_q <= rx_shift_d;
      rx_hold_q <= rx_hold_d;
      tx_shift_q <= tx_shift_d;
      tx_hold_q <= tx_hold_d;
      pend_q <= pend_d;
      pend_hold_q <= pend_hold_d;
      primed_q <= primed_d;
      rrdy_q <= rrdy_d;
      roe_q <= roe_d;
      toe_q <= toe_d;
      tur_q <= tur_d;
      abt_q <= abt_d;
      ctrl_q <= ctrl_d;
      data_to_cpu_q <= data_to_cpu_d;
      irq_q <= irq_d;
    end
  end
endmodule

// File: tb/tb_spi_slave_port.sv
// tb_spi_slave_port: vector table, corner-case sequences and a random run against a frame-level model.
`timescale 1ns/1ps
module tb_spi_slave_port;
  logic clk = 1'b0;
  logic reset_n, SCLK, SS_n, MOSI, MISO, MISO_oe;
  int checks = 0;
  int errors = 0;
  localparam logic [7:0] IDLE = 8'h00;
  spi_slave_port_if bus ();
  spi_slave_port dut (.clk(clk), .reset_n(reset_n), .bus(bus), .SCLK(SCLK), .SS_n(SS_n),
                      .MOSI(MOSI), .MISO(MISO), .MISO_oe(MISO_oe));
  always #5 clk = ~clk;
  typedef struct {
    logic prime; logic [7:0] tx; logic [7:0] mosi; logic [5:0] ctrl;
    logic [7:0] exp_miso; logic [15:0] exp_stat; logic exp_irq;
  } vec_t;
  vec_t vecs[6];
  logic m_primed, m_rrdy, m_roe, m_toe, m_tur, m_abt;
  logic [7:0] m_txh, m_rxh;
  logic [5:0] m_ctrl;
  function automatic logic [15:0] mstat();
    return {6'd0, m_roe | m_toe | m_tur | m_abt, m_rrdy, ~m_primed, m_roe, m_toe, m_tur, m_abt, 3'd0};
  endfunction
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic cpu_write(input logic [2:0] a, input logic [15:0] d);
    bus.spi_select = 1'b1; bus.mem_addr = a; bus.data_from_cpu = d; bus.write_n = 1'b0;
    tick(1);
    bus.spi_select = 1'b0; bus.write_n = 1'b1;
  endtask
  task automatic cpu_read(input logic [2:0] a, output logic [15:0] d);
    bus.spi_select = 1'b1; bus.mem_addr = a; bus.read_n = 1'b0;
    tick(1);
    bus.spi_select = 1'b0; bus.read_n = 1'b1;
    d = bus.data_to_cpu;
  endtask
  task automatic spi_word(input logic [7:0] mo, input int n, output logic [7:0] mi);
    mi = '0;
    for (int i = 0; i < n; i++) begin
      MOSI = mo[7-i];
      tick(4);
      mi = {mi[6:0], MISO};
      SCLK = 1'b1;
      tick(4);
      SCLK = 1'b0;
    end
  endtask
  task automatic frame(input logic [7:0] mo, output logic [7:0] mi);
    SS_n = 1'b0;
    tick(8);
    spi_word(mo, 8, mi);
    tick(4);
    SS_n = 1'b1;
    tick(6);
  endtask
  task automatic pulse_reset();
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(3);
  endtask
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [15:0] rd, v, s;
    logic [7:0] mi, ew;
    int op;
    vecs[0] = '{1'b1, 8'hA5, 8'h3C, 6'b000000, 8'hA5, 16'h0180, 1'b0};
    vecs[1] = '{1'b0, 8'h00, 8'h5A, 6'b000010, IDLE,  16'h0390, 1'b1};
    vecs[2] = '{1'b0, 8'h00, 8'hFF, 6'b000000, IDLE,  16'h0390, 1'b0};
    vecs[3] = '{1'b0, 8'h00, 8'h00, 6'b000001, IDLE,  16'h0390, 1'b0};
    vecs[4] = '{1'b1, 8'h81, 8'h7E, 6'b100000, 8'h81, 16'h0180, 1'b1};
    vecs[5] = '{1'b1, 8'hFF, 8'h01, 6'b000010, 8'hFF, 16'h0180, 1'b0};
    reset_n = 1'b0; SCLK = 1'b0; SS_n = 1'b1; MOSI = 1'b0;
    bus.spi_select = 1'b0; bus.mem_addr = '0; bus.read_n = 1'b1; bus.write_n = 1'b1; bus.data_from_cpu = '0;
    tick(3);
    reset_n = 1'b1;
    tick(2);
    check("rst data_to_cpu", bus.data_to_cpu, 16'h0000);
    check("rst irq", 16'(bus.irq), 16'h0);
    check("rst miso", 16'(MISO), 16'h0);
    check("rst miso_oe", 16'(MISO_oe), 16'h0);
    cpu_read(3'd2, rd); check("rst status", rd, 16'h0080);
    cpu_read(3'd3, rd); check("rst control", rd, 16'h0000);
    for (int i = 0; i < 6; i++) begin
      cpu_write(3'd3, {7'd0, vecs[i].ctrl, 3'd0});
      cpu_write(3'd2, 16'h0);
      cpu_read(3'd0, rd);
      if (vecs[i].prime) cpu_write(3'd1, {8'd0, vecs[i].tx});
      frame(vecs[i].mosi, mi);
      check($sformatf("vec%0d miso", i), {8'd0, mi}, {8'd0, vecs[i].exp_miso});
      check($sformatf("vec%0d irq", i), 16'(bus.irq), 16'(vecs[i].exp_irq));
      cpu_read(3'd2, rd); check($sformatf("vec%0d status", i), rd, vecs[i].exp_stat);
      cpu_read(3'd0, rd); check($sformatf("vec%0d rxdata", i), rd, {8'd0, vecs[i].mosi});
    end
    cpu_write(3'd3, 16'h0);
    cpu_write(3'd2, 16'h0);
    frame(8'h12, mi);
    frame(8'h34, mi);
    cpu_read(3'd2, rd); check("roe status", rd, 16'h03D0);
    cpu_write(3'd2, 16'hFFFF);
    cpu_read(3'd2, rd); check("roe cleared", rd, 16'h0180);
    cpu_read(3'd0, rd); check("roe rxdata", rd, 16'h0034);
    cpu_write(3'd1, 16'h0011);
    cpu_write(3'd1, 16'h0022);
    cpu_read(3'd2, rd); check("toe status", rd, 16'h0220);
    frame(8'h00, mi);
    check("toe miso", {8'd0, mi}, 16'h0011);
    cpu_read(3'd0, rd);
    cpu_write(3'd2, 16'h0);
    SS_n = 1'b0;
    tick(8);
    spi_word(8'hF0, 5, mi);
    tick(4);
    SS_n = 1'b1;
    tick(6);
    cpu_read(3'd2, rd); check("abort status", rd, 16'h0298);
    frame(8'h81, mi);
    cpu_read(3'd0, rd); check("abort next rx", rd, 16'h0081);
    cpu_write(3'd2, 16'h0);
    cpu_write(3'd3, {7'd0, 6'b010000, 3'd0});
    cpu_read(3'd3, rd); check("control readback", rd, 16'h0080);
    cpu_write(3'd1, 16'h00C3);
    tick(2);
    check("bb irq primed", 16'(bus.irq), 16'h0);
    SS_n = 1'b0;
    for (int i = 0; i < 20 && !bus.irq; i++) tick(1);
    check("bb irq trdy", 16'(bus.irq), 16'h1);
    cpu_write(3'd1, 16'h003C);
    spi_word(8'h11, 8, mi);
    check("bb miso1", {8'd0, mi}, 16'h00C3);
    cpu_read(3'd0, rd); check("bb rx1", rd, 16'h0011);
    spi_word(8'h22, 8, mi);
    check("bb miso2", {8'd0, mi}, 16'h003C);
    tick(4);
    SS_n = 1'b1;
    tick(6);
    cpu_read(3'd2, rd); check("bb status", rd, 16'h0180);
    cpu_read(3'd0, rd); check("bb rx2", rd, 16'h0022);
    SS_n = 1'b0;
    tick(8);
    spi_word(8'hAA, 3, mi);
    reset_n = 1'b0; SS_n = 1'b1;
    tick(2);
    check("midrst miso_oe", 16'(MISO_oe), 16'h0);
    check("midrst miso", 16'(MISO), 16'h0);
    reset_n = 1'b1;
    tick(4);
    cpu_read(3'd2, rd); check("midrst status", rd, 16'h0080);
    cpu_write(3'd1, 16'h0096);
    frame(8'h69, mi);
    check("midrst miso next", {8'd0, mi}, 16'h0096);
    cpu_read(3'd0, rd); check("midrst rx next", rd, 16'h0069);
    pulse_reset();
    m_primed = 0; m_rrdy = 0; m_roe = 0; m_toe = 0; m_tur = 0; m_abt = 0;
    m_txh = '0; m_rxh = '0; m_ctrl = '0;
    for (int k = 0; k < 40; k++) begin
      op = int'($urandom_range(0, 6));
      v = 16'($urandom);
      if (op == 0) begin
        cpu_write(3'd1, v);
        if (m_primed) m_toe = 1'b1;
        else begin m_primed = 1'b1; m_txh = v[7:0]; end
      end else if (op <= 2) begin
        frame(v[7:0], mi);
        ew = m_primed ? m_txh : IDLE;
        if (!m_primed) m_tur = 1'b1;
        m_primed = 1'b0;
        if (m_rrdy) m_roe = 1'b1;
        m_rrdy = 1'b1;
        m_rxh = v[7:0];
        check($sformatf("rnd%0d miso", k), {8'd0, mi}, {8'd0, ew});
      end else if (op == 3) begin
        cpu_read(3'd0, rd);
        check($sformatf("rnd%0d rxdata", k), rd, {8'd0, m_rxh});
        m_rrdy = 1'b0;
      end else if (op == 4) begin
        cpu_read(3'd2, rd);
        check($sformatf("rnd%0d status", k), rd, mstat());
      end else if (op == 5) begin
        cpu_write(3'd2, v);
        m_roe = 0; m_toe = 0; m_tur = 0; m_abt = 0;
      end else begin
        cpu_write(3'd3, v);
        m_ctrl = v[8:3];
      end
      tick(2);
      s = mstat();
      check($sformatf("rnd%0d irq", k), 16'(bus.irq), 16'(|(s[8:3] & m_ctrl)));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
